// File: rtl/esfa_pkg.sv
// esfa_pkg: shared ESFA field width, operation bundle, arbiter states and idle selector
package esfa_pkg;
  localparam int ESFA_FIELD_W = 8;
  localparam logic [ESFA_FIELD_W-1:0] ESFA_IDLE_SEL = 8'h00;
  typedef struct packed {
    logic [ESFA_FIELD_W-1:0] handle;
    logic [ESFA_FIELD_W-1:0] index;
    logic [ESFA_FIELD_W-1:0] value;
    logic [ESFA_FIELD_W-1:0] selector;
  } esfa_op_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/esfa_rr_picker.sv
// esfa_rr_picker: combinational round-robin pick, search starts just after the last grant
module esfa_rr_picker #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic          found;
  logic [IW-1:0] j;
  // scan ptr+1 .. ptr+N with wrap; the first requester seen wins
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        idx = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/esfa_op_arbiter.sv
// esfa_op_arbiter: round-robin sharing of one ESFA datapath; ESFA_ARB_STATS_EN builds grant counters
module esfa_op_arbiter
  import esfa_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int OP_CYCLES = 2,
  parameter logic [ESFA_FIELD_W-1:0] IDLE_SEL = ESFA_IDLE_SEL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [8*NUM_REQ-1:0]    req_handle,
  input  logic [8*NUM_REQ-1:0]    req_index,
  input  logic [8*NUM_REQ-1:0]    req_value,
  input  logic [8*NUM_REQ-1:0]    req_selector,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic                    resp_bool,
  output logic [7:0]              resp_value,
  output logic [7:0]              esfa_handle,
  output logic [7:0]              esfa_index,
  output logic [7:0]              esfa_value,
  output logic [7:0]              esfa_selector,
  input  logic                    esfa_result_bool,
  input  logic [7:0]              esfa_result_value,
  output logic                    busy,
  output logic [16*NUM_REQ-1:0]   grant_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam esfa_op_t IDLE_OP = '{handle: '0, index: '0, value: '0, selector: IDLE_SEL};
  arb_state_t state, nxt;
  logic [3:0] cnt;
  logic [IW-1:0] ptr, win, pick;
  logic [NUM_REQ-1:0] grant;
  logic hs;
  esfa_op_t op, bus;
  esfa_rr_picker #(.N(NUM_REQ)) u_pick (.req(req_valid), .ptr(ptr), .grant(grant), .idx(pick));
  // accept the round-robin winner only while idle and out of reset; select its fields
  always_comb begin
    req_ready = (state == IDLE && reset) ? grant : '0;
    hs = |req_ready;
    op = '{handle: req_handle[{pick, 3'b000} +: 8], index: req_index[{pick, 3'b000} +: 8],
           value: req_value[{pick, 3'b000} +: 8], selector: req_selector[{pick, 3'b000} +: 8]};
    nxt = (state == IDLE) ? (hs ? EXEC : IDLE) : (state == EXEC) ? (cnt == '0 ? RESP : EXEC) : IDLE;
  end
  // state register
  always_ff @(posedge clk) state <= !reset ? IDLE : nxt;
  // bus hold, hold counter, pointer and result capture; the bus goes idle as the result is taken
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus <= IDLE_OP;
      cnt <= '0;
      ptr <= IW'(NUM_REQ - 1);
      win <= '0;
      resp_valid <= '0;
      resp_bool <= 1'b0;
      resp_value <= '0;
    end else begin
      resp_valid <= '0;
      if (hs) begin
        bus <= op;
        cnt <= 4'(OP_CYCLES - 1);
        ptr <= pick;
        win <= pick;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == '0) begin
          bus <= IDLE_OP;
          resp_valid <= NUM_REQ'(1) << win;
          resp_bool <= esfa_result_bool;
          resp_value <= esfa_result_value;
        end
      end
    end
  end
  assign esfa_handle = bus.handle;
  assign esfa_index = bus.index;
  assign esfa_value = bus.value;
  assign esfa_selector = bus.selector;
  assign busy = state != IDLE;
`ifdef ESFA_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [15:0] c;
    // saturating count of this requester's handshakes
    always_ff @(posedge clk)
      if (!reset) c <= '0;
      else if (hs && grant[i] && c != 16'hFFFF) c <= c + 16'd1;
    assign grant_count[16*i +: 16] = c;
  end
`else
  assign grant_count = '0;
`endif
endmodule
